// File: rtl/multi_cycle_mips_control.sv
// Multi-cycle MIPS control unit. A registered FSM sequences each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over one shared memory port and one shared ALU.
//
// state     | meaning
// FETCH     | request instruction at PC, compute PC+4, load IR on mem_ready
// DECODE    | one cycle to classify the registered IR
// EXECUTE   | ALU op, branch/jump resolution, illegal detection
// MEMORY    | load/store access at ALU result, held until mem_ready
// WRITEBACK | register file write of ALU result or load data
module multi_cycle_mips_control #(
   parameter bit ENABLE_EXTENDED = 1'b1,
   parameter int INSTRET_WIDTH   = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              mem_rdata,
   input  logic                     mem_ready,
   input  logic                     alu_zero,
   output logic                     mem_req,
   output logic                     mem_write,
   output logic                     mem_addr_source,
   output logic                     pc_write,
   output logic [1:0]               pc_source,
   output logic                     alu_a_source,
   output logic [1:0]               alu_b_source,
   output logic [2:0]               alu_ctrl,
   output logic                     imm_zero_extend,
   output logic                     register_write_enable,
   output logic [1:0]               register_write_address_source,
   output logic [1:0]               register_write_data_source,
   output logic [4:0]               src_register_addr,
   output logic [4:0]               dst_register_addr,
   output logic [4:0]               r_register_addr,
   output logic [4:0]               shift_amt,
   output logic [15:0]              immediate,
   output logic [25:0]              jump_imm_addr,
   output logic [2:0]               state,
   output logic                     illegal_instruction,
   output logic [INSTRET_WIDTH-1:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      C_RTYPE, C_SHIFT, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ILLEGAL
   } class_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b011;
   localparam logic [2:0] ALU_SRL = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t                   r_state;
   state_t                   w_next_state;
   logic [31:0]              r_ir;
   logic                     r_illegal;
   logic [INSTRET_WIDTH-1:0] r_instret;

   logic [5:0] w_opcode;
   logic [5:0] w_funct;
   class_t     w_class;
   logic [2:0] w_alu_op;
   logic       w_zext;
   logic       w_ir_load;
   logic       w_retire;
   logic       w_set_illegal;

   assign w_opcode = r_ir[31:26];
   assign w_funct  = r_ir[5:0];

   always_comb begin
      w_class  = C_ILLEGAL;
      w_alu_op = ALU_ADD;
      w_zext   = 1'b0;
      case (w_opcode)
         6'h00: begin
            case (w_funct)
               6'h20: begin w_class = C_RTYPE; w_alu_op = ALU_ADD; end
               6'h22: begin w_class = C_RTYPE; w_alu_op = ALU_SUB; end
               6'h24: begin w_class = C_RTYPE; w_alu_op = ALU_AND; end
               6'h25: begin w_class = C_RTYPE; w_alu_op = ALU_OR;  end
               6'h00: begin w_class = C_SHIFT; w_alu_op = ALU_SLL; end
               6'h2A: if (ENABLE_EXTENDED) begin w_class = C_RTYPE; w_alu_op = ALU_SLT; end
               6'h02: if (ENABLE_EXTENDED) begin w_class = C_SHIFT; w_alu_op = ALU_SRL; end
               default: ;
            endcase
         end
         6'h08: begin w_class = C_IALU; w_alu_op = ALU_ADD; end
         6'h0C: begin w_class = C_IALU; w_alu_op = ALU_AND; w_zext = 1'b1; end
         6'h0D: if (ENABLE_EXTENDED) begin w_class = C_IALU; w_alu_op = ALU_OR; w_zext = 1'b1; end
         6'h23: w_class = C_LW;
         6'h2B: w_class = C_SW;
         6'h04: w_class = C_BEQ;
         6'h05: if (ENABLE_EXTENDED) w_class = C_BNE;
         6'h02: w_class = C_J;
         6'h03: if (ENABLE_EXTENDED) w_class = C_JAL;
         default: ;
      endcase
   end

   // Shifts take their operand from rt, so the register fields slide down one slot.
   assign src_register_addr = (w_class == C_SHIFT) ? r_ir[20:16] : r_ir[25:21];
   assign dst_register_addr = (w_class == C_SHIFT) ? r_ir[15:11] : r_ir[20:16];
   assign r_register_addr   = r_ir[15:11];
   assign shift_amt         = r_ir[10:6];
   assign immediate         = r_ir[15:0];
   assign jump_imm_addr     = r_ir[25:0];
   assign state             = r_state;
   assign illegal_instruction = r_illegal;
   assign instret           = r_instret;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_ir      <= '0;
         r_illegal <= 1'b0;
         r_instret <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_ir_load)     r_ir      <= mem_rdata;
         if (w_set_illegal) r_illegal <= 1'b1;
         if (w_retire)      r_instret <= r_instret + INSTRET_WIDTH'(1);
      end
   end

   always_comb begin
      mem_req                       = 1'b0;
      mem_write                     = 1'b0;
      mem_addr_source               = 1'b0;
      pc_write                      = 1'b0;
      pc_source                     = 2'd0;
      alu_a_source                  = 1'b0;
      alu_b_source                  = 2'd0;
      alu_ctrl                      = 3'b000;
      imm_zero_extend               = 1'b0;
      register_write_enable         = 1'b0;
      register_write_address_source = 2'd0;
      register_write_data_source    = 2'd0;
      w_next_state                  = r_state;
      w_ir_load                     = 1'b0;
      w_retire                      = 1'b0;
      w_set_illegal                 = 1'b0;
      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               mem_req      = 1'b1;
               alu_b_source = 2'd3;
               alu_ctrl     = ALU_ADD;
               if (mem_ready) begin
                  w_ir_load    = 1'b1;
                  pc_write     = 1'b1;
                  w_next_state = S_DECODE;
               end
            end
            S_DECODE: w_next_state = S_EXECUTE;
            S_EXECUTE: begin
               w_next_state = S_FETCH;
               case (w_class)
                  C_RTYPE, C_SHIFT: begin
                     alu_a_source = 1'b1;
                     alu_b_source = (w_class == C_SHIFT) ? 2'd2 : 2'd0;
                     alu_ctrl     = w_alu_op;
                     w_next_state = S_WRITEBACK;
                  end
                  C_IALU: begin
                     alu_a_source    = 1'b1;
                     alu_b_source    = 2'd1;
                     alu_ctrl        = w_alu_op;
                     imm_zero_extend = w_zext;
                     w_next_state    = S_WRITEBACK;
                  end
                  C_LW, C_SW: begin
                     alu_a_source = 1'b1;
                     alu_b_source = 2'd1;
                     alu_ctrl     = ALU_ADD;
                     w_next_state = S_MEMORY;
                  end
                  C_BEQ, C_BNE: begin
                     alu_a_source = 1'b1;
                     alu_ctrl     = ALU_SUB;
                     pc_write     = (w_class == C_BEQ) ? alu_zero : !alu_zero;
                     pc_source    = 2'd1;
                     w_retire     = 1'b1;
                  end
                  C_J, C_JAL: begin
                     pc_write  = 1'b1;
                     pc_source = 2'd2;
                     w_retire  = 1'b1;
                     if (w_class == C_JAL) begin
                        register_write_enable         = 1'b1;
                        register_write_address_source = 2'd2;
                        register_write_data_source    = 2'd2;
                     end
                  end
                  default: w_set_illegal = 1'b1;
               endcase
            end
            S_MEMORY: begin
               mem_req         = 1'b1;
               mem_addr_source = 1'b1;
               mem_write       = (w_class == C_SW);
               if (mem_ready) begin
                  if (w_class == C_SW) begin
                     w_retire     = 1'b1;
                     w_next_state = S_FETCH;
                  end else begin
                     w_next_state = S_WRITEBACK;
                  end
               end
            end
            S_WRITEBACK: begin
               register_write_enable         = 1'b1;
               register_write_address_source = (w_class == C_RTYPE || w_class == C_SHIFT) ? 2'd1 : 2'd0;
               register_write_data_source    = (w_class == C_LW) ? 2'd1 : 2'd0;
               w_retire                      = 1'b1;
               w_next_state                  = S_FETCH;
            end
            default: w_next_state = S_FETCH;
         endcase
      end
   end

endmodule

// File: doc/multi_cycle_mips_control.md
# multi_cycle_mips_control

Multi-cycle successor to the single-cycle MIPS control decoder. It replaces per-instruction combinational decode with a registered FSM, so that one shared memory port and one ALU serve every phase of an instruction. It also adds a memory ready handshake, an optional extended opcode set, an illegal-instruction flag and a retired-instruction counter. It sits between the datapath's PC/IR/ALU/register file and a unified instruction/data memory with variable latency.

## Interface
- `ENABLE_EXTENDED`, default 1: when 1, decodes ori, bne, slt, srl and jal; when 0, these opcodes are illegal.
- `INSTRET_WIDTH`, default 32: width of the retired-instruction counter.

Ports, as name  direction  width  meaning:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_rdata`  in  32  memory read data; captured into the IR at fetch.
- `mem_ready`  in  1  memory completed the current request this cycle.
- `alu_zero`  in  1  ALU result == 0.
- `mem_req`  out  1  memory request valid.
- `mem_write`  out  1  request is a store.
- `mem_addr_source`  out  1  0 = PC, 1 = ALU result register.
- `pc_write`  out  1  load PC this cycle.
- `pc_source`  out  2  0 = ALU (PC+4), 1 = branch target, 2 = jump target {PC[31:28], jump_imm_addr, 2'b00}.
- `alu_a_source`  out  1  0 = PC, 1 = register output 1.
- `alu_b_source`  out  2  0 = register output 2, 1 = immediate, 2 = shift immediate, 3 = constant 4.
- `alu_ctrl`  out  3  000 and, 001 or, 010 add, 011 sll, 100 srl, 110 sub, 111 slt.
- `imm_zero_extend`  out  1  1 for andi/ori, 0 for sign extension.
- `register_write_enable`  out  1  single-cycle register-file write pulse.
- `register_write_address_source`  out  2  0 = rt, 1 = rd, 2 = $31.
- `register_write_data_source`  out  2  0 = ALU result, 1 = memory data register, 2 = PC.
- `src_register_addr`, `dst_register_addr`, `r_register_addr`, `shift_amt`  out  5 each  fields decoded from the IR.
- `immediate`  out  16  IR[15:0].
- `jump_imm_addr`  out  26  IR[25:0].
- `state`  out  3  current FSM state.
- `illegal_instruction`  out  1  sticky; cleared only by reset.
- `instret`  out  INSTRET_WIDTH  count of retired instructions.

## Operation
- FSM states: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4.
- Decode fields always reflect the registered IR. For sll/srl, src is IR[20:16] and dst is IR[15:11].
- **FETCH**
  - Drives mem_req=1, mem_addr_source=0, alu_a=PC, alu_b=3, alu_ctrl=add.
  - On mem_ready: IR <= mem_rdata, pc_write=1 with pc_source=0, next state DECODE.
  - Otherwise stays in FETCH.
- **DECODE**: one cycle. Classifies the opcode; next state EXECUTE.
- **EXECUTE** behaviour by class:
  - R-type (add/and/or/sub, plus slt/srl if extended, plus sll): alu_a=1; alu_b=0 (shifts: alu_b=2). Next WRITEBACK.
  - addi, andi, ori: alu_a=1, alu_b=1. Next WRITEBACK.
  - lw, sw: add with alu_a=1, alu_b=1. Next MEMORY.
  - beq, bne: sub with alu_a=1, alu_b=0. pc_write = alu_zero for beq, !alu_zero for bne; pc_source=1. Retires; next FETCH.
  - j: pc_write=1, pc_source=2. Retires; next FETCH.
  - jal: same as j, plus register_write_enable=1, address source 2, data source 2. The PC already holds PC+4. Retires; next FETCH.
  - Illegal opcode or funct: no writes; illegal_instruction <= 1; does not retire; next FETCH.
- **MEMORY**
  - Drives mem_req=1, mem_addr_source=1, mem_write = (sw).
  - On mem_ready: lw goes to WRITEBACK; sw retires and goes to FETCH.
- **WRITEBACK**: register_write_enable=1.
  - Address source: 0 for I-type, 1 for R-type.
  - Data source: 1 for lw, 0 otherwise.
  - Retires; next FETCH.
- instret increments by 1 on each retiring cycle and wraps modulo 2^INSTRET_WIDTH.

## Timing
- All outputs not listed for a state are 0. Outputs are a combinational function of state and IR; state, IR, illegal_instruction and instret are registers.
- Reset values: state=FETCH, IR=0, illegal_instruction=0, instret=0.
- While reset is high, every control output is forced to 0, including mem_req and pc_write.
- The first FETCH request is driven in the cycle after reset deasserts.
- Reset asserted mid-instruction abandons it: no writes, no retire, and mem_req drops in that same cycle.
- Handshake rules:
  - mem_req, mem_write and mem_addr_source stay stable until the cycle in which mem_ready is sampled high.
  - mem_ready is ignored while mem_req=0.
  - mem_ready held high continuously gives zero wait states.
- Latency with zero wait states:
  - branch, jump, illegal: 3 cycles.
  - R-type, I-ALU, sw: 4 cycles.
  - lw: 5 cycles.
- Each wait cycle in FETCH or MEMORY adds 1 cycle.

## Test plan
- add $3,$1,$2 (0x00221820), mem_ready=1 → states 0,1,2,4. In WRITEBACK: write_en=1, addr_src=1, alu_ctrl=010 in EXECUTE. instret 0→1.
- lw $2,8($1) (0x8C220008), 2 wait cycles in MEMORY → mem_req held with addr_src=1 for 3 cycles. WRITEBACK has data_src=1, addr_src=0. 7 cycles total.
- beq $1,$2 with alu_zero=1, then alu_zero=0 → pc_write=1 with pc_source=1 in the first case, pc_write=0 in the second. Each takes 3 cycles.
- ENABLE_EXTENDED=0, fetch ori (0x34220005) → illegal_instruction=1 and stays 1, no register_write_enable, instret unchanged. Next fetch proceeds normally.
- jal 0x0100000 → pc_write=1, pc_source=2, write_en=1, addr_src=2, data_src=2 in EXECUTE.
- Reset pulsed during MEMORY of sw → mem_write never completes; state=FETCH and instret=0 after reset.
- INSTRET_WIDTH=2, retire 5 instructions → instret=1.
